ram2flash_if: RTL
=================

Name: ram2flash_if

Overview:
- Readback/dump engine: reads instruction memory out of the four byte-lane RAM banks and streams it byte-serially to the flash programming path, using a valid/ready handshake.
- Mirrors the flash-to-RAM load path, which writes byte k into lane k[1:0] at word k[IMEM_WIDTH-1:2]. This block reads bytes back in the same order, starting from byte address 0.
- Sits between the IMEM banks (read port) and the flash write/program controller.

Parameters:
- IMEM_WIDTH, 19, byte-address width of instruction memory; word address is IMEM_WIDTH-2 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- byte_count  in  IMEM_WIDTH+1  number of bytes to send, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the dump completes
- ram_ren  out  1  RAM read enable, all four banks
- ram_addr  out  IMEM_WIDTH-2  RAM word address
- ram0_dout..ram3_dout  in  8 each  bank read data; valid one cycle after ram_ren
- flash_wdata  out  8  byte to flash side
- flash_wdata_valid  out  1  flash_wdata is valid
- flash_wdata_ready  in  1  flash side accepts the byte

Behaviour:
- Reset values: busy=0, done=0, ram_ren=0, ram_addr=0, flash_wdata=0, flash_wdata_valid=0, internal byte index=0, state=IDLE.
- States and transitions:
  - IDLE: on start, latch byte_count into remaining and clear byte index to 0. If byte_count is zero, go to FIN. Otherwise go to RD.
  - RD (one cycle): ram_ren=1, ram_addr=index[IMEM_WIDTH-1:2]. Next state is WAIT.
  - WAIT (one cycle): ram_ren=0. At the end of the cycle, capture {ram3,ram2,ram1,ram0}_dout into a 32-bit word buffer. Next state is SEND.
  - SEND: flash_wdata = buffer lane index[1:0]; flash_wdata_valid=1.
    - A byte transfers on any rising edge where valid && ready. On transfer: index+1, remaining-1.
    - If remaining becomes 0, go to FIN.
    - Else if index[1:0] was 3, go to RD (fetch next word).
    - Else stay in SEND with the next lane.
  - FIN (one cycle): done=1, busy=0 in that cycle. Next state is IDLE.
- busy is 1 in RD, WAIT and SEND; 0 in IDLE and FIN.
- Latency: start sampled at edge E0. ram_ren is high in the E0–E1 cycle, the word is captured at E2, and flash_wdata_valid rises after E2. With ready held high, the first byte transfers at E3.
- Each subsequent in-word byte needs 1 cycle with ready high. Crossing a word boundary costs 2 bubble cycles (RD and WAIT), with valid=0.
- Handshake rules:
  - While valid && !ready, flash_wdata and valid hold stable.
  - valid never drops without a transfer, except on reset.
  - ready is ignored when valid=0.
- byte_count clamping: values above 2^IMEM_WIDTH are clamped to 2^IMEM_WIDTH (the full memory). The index does not wrap within a dump.
- Partial last word: when byte_count is not a multiple of 4, sending stops after lane (byte_count-1)[1:0]. No extra RAM read is issued.
- byte_count=0: no ram_ren and no valid; done pulses at E1.
- start asserted while busy or in FIN: ignored, no latching, no effect.
- Mid-operation reset: everything returns asynchronously to reset values and flash_wdata_valid drops immediately. The next start begins again at byte 0.
- ram_addr holds its last value outside RD; only ram_ren qualifies it.

Test Plan:
- RAM words 0:0x44332211, 1:0x88776655; byte_count=8; ready=1 -> flash bytes 11,22,33,44,55,66,77,88. First valid after E2, 2-cycle gap between 44 and 55, done pulse one cycle after byte 88 transfers, busy low after.
- Same data, byte_count=5, ready toggling 1,0,0,1,... -> bytes 11,22,33,44,55 only. Data is stable during ready=0, exactly 2 ram_ren pulses (addr 0, 1), then done.
- byte_count=0 -> done pulses at E1, no ram_ren, no valid, busy never high.
- start pulsed again mid-dump with byte_count=2 -> ignored; original 8-byte sequence completes unchanged with a single done.
- rst_n asserted while valid=1 and ready=0 after 3 bytes -> valid/busy drop at once. A new start with byte_count=4 then yields 11,22,33,44 from address 0.
- IMEM_WIDTH=6, byte_count=64 (clamp check with 100) -> exactly 64 bytes, 16 ram_ren pulses with addresses 0..15, no wrap.

Source files
------------

// File: rtl/ram2flash_if.sv
// Instruction-memory dump engine: reads the four byte-lane IMEM banks word by word
// and streams the bytes, lane 0 first, to the flash programming path over valid/ready.
module ram2flash_if #(
  parameter int IMEM_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IMEM_WIDTH:0]   byte_count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ren,
  output logic [IMEM_WIDTH-3:0] ram_addr,
  input  logic [7:0]            ram0_dout,
  input  logic [7:0]            ram1_dout,
  input  logic [7:0]            ram2_dout,
  input  logic [7:0]            ram3_dout,
  output logic [7:0]            flash_wdata,
  output logic                  flash_wdata_valid,
  input  logic                  flash_wdata_ready
);

  localparam logic [IMEM_WIDTH:0] MAX_BYTES = {1'b1, {IMEM_WIDTH{1'b0}}};
  localparam logic [IMEM_WIDTH:0] ONE       = {{IMEM_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, FIN} state_t;

  state_t                state_reg, state_next;
  logic [IMEM_WIDTH:0]   index_reg, index_next;
  logic [IMEM_WIDTH:0]   remaining_reg, remaining_next;
  logic [31:0]           word_reg, word_next;
  logic [IMEM_WIDTH-3:0] addr_reg, addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      remaining_reg <= '0;
      word_reg      <= '0;
      addr_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      remaining_reg <= remaining_next;
      word_reg      <= word_next;
      addr_reg      <= addr_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    index_next        = index_reg;
    remaining_next    = remaining_reg;
    word_next         = word_reg;
    addr_next         = addr_reg;
    busy              = 1'b0;
    done              = 1'b0;
    ram_ren           = 1'b0;
    flash_wdata       = 8'h00;
    flash_wdata_valid = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          index_next     = '0;
          remaining_next = (byte_count > MAX_BYTES) ? MAX_BYTES : byte_count;
          if (byte_count == '0) begin
            state_next = FIN;
          end else begin
            state_next = RD;
            addr_next  = '0;
          end
        end
      end
      RD: begin
        busy       = 1'b1;
        ram_ren    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy       = 1'b1;
        word_next  = {ram3_dout, ram2_dout, ram1_dout, ram0_dout};
        state_next = SEND;
      end
      SEND: begin
        busy              = 1'b1;
        flash_wdata_valid = 1'b1;
        flash_wdata       = word_reg[{index_reg[1:0], 3'b000} +: 8];
        if (flash_wdata_ready) begin
          index_next     = index_reg + ONE;
          remaining_next = remaining_reg - ONE;
          // Remaining count ends the dump before a word boundary can trigger a fetch,
          // so a partial last word never costs an extra RAM read.
          if (remaining_reg == ONE) begin
            state_next = FIN;
          end else if (index_reg[1:0] == 2'd3) begin
            state_next = RD;
            addr_next  = index_next[IMEM_WIDTH-1:2];
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_addr = addr_reg;

endmodule
